// File: rtl/display_mode_controller.sv
// Lock display controller: passcode entry with blinking cursor,
// blinking error pattern and steady unlocked pattern.
//
// Ports:
//   clock, reset      system clock, async active-high reset
//   error, unlocked   state request levels (error has priority)
//   digitCount        digits entered so far (saturates at PASSCODE_LENGTH)
//   userEntry         entered digits, digit 0 in the top nibble
//   hexOut            registered nibble per display, display 0 on top
//   displayOn         registered per-digit enable, bit k = display k
//   mode              registered state: 0 INPUT, 1 ERROR, 2 UNLOCKED
module display_mode_controller #(
  parameter int PASSCODE_LENGTH = 4,
  parameter int PASSCODE_WIDTH = 4*PASSCODE_LENGTH,
  parameter int DISPLAYS = 6,
  parameter int BLINK_HALF_PERIOD = 25000000,
  parameter logic [3:0] FILL_CODE = 4'hE,
  parameter logic [4*DISPLAYS-1:0] ERROR_PATTERN = 24'hFCDDED,
  parameter logic [4*DISPLAYS-1:0] UNLOCK_PATTERN = 24'hEE0AB1,
  localparam int DW = $clog2(PASSCODE_LENGTH+1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      error,
  input  logic                      unlocked,
  input  logic [DW-1:0]             digitCount,
  input  logic [PASSCODE_WIDTH-1:0] userEntry,
  output logic [4*DISPLAYS-1:0]     hexOut,
  output logic [DISPLAYS-1:0]       displayOn,
  output logic [1:0]                mode
);

  localparam int CW = $clog2(BLINK_HALF_PERIOD);

  if (PASSCODE_LENGTH > DISPLAYS || PASSCODE_LENGTH < 1) begin : g_bad_len
    $error("PASSCODE_LENGTH must be 1..DISPLAYS");
  end
  if (BLINK_HALF_PERIOD < 2) begin : g_bad_blink
    $error("BLINK_HALF_PERIOD must be >= 2");
  end

  typedef enum logic [1:0] {
    S_INPUT  = 2'd0,
    S_ERROR  = 2'd1,
    S_UNLOCK = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic [4*DISPLAYS-1:0]   hex_q, hex_d;
  logic [DISPLAYS-1:0]     on_q, on_d;
  logic [DW-1:0]           n_sat;

  always_comb begin
    state_d = S_INPUT;
    if (error) begin
      state_d = S_ERROR;
    end else if (unlocked) begin
      state_d = S_UNLOCK;
    end

    // A state change restarts the blink so the new state opens "on".
    cnt_d = cnt_q + CW'(1);
    phase_d = phase_q;
    if (state_d != state_q) begin
      cnt_d = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CW'(BLINK_HALF_PERIOD-1)) begin
      cnt_d = '0;
      phase_d = ~phase_q;
    end

    n_sat = digitCount;
    if (digitCount > DW'(PASSCODE_LENGTH)) begin
      n_sat = DW'(PASSCODE_LENGTH);
    end

    hex_d = {DISPLAYS{FILL_CODE}};
    on_d = '1;
    unique case (state_d)
      S_ERROR: begin
        hex_d = ERROR_PATTERN;
        on_d = {DISPLAYS{phase_d}};
      end
      S_UNLOCK: begin
        hex_d = UNLOCK_PATTERN;
      end
      default: begin
        for (int k = 0; k < PASSCODE_LENGTH; k++) begin
          if (k < int'(n_sat)) begin
            hex_d[4*(DISPLAYS-1-k) +: 4] =
              userEntry[4*(PASSCODE_LENGTH-1-k) +: 4];
          end
          if (k == int'(n_sat)) begin
            on_d[k] = phase_d;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_INPUT;
      cnt_q <= '0;
      phase_q <= 1'b1;
      hex_q <= {DISPLAYS{FILL_CODE}};
      on_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      hex_q <= hex_d;
      on_q <= on_d;
    end
  end

  assign hexOut = hex_q;
  assign displayOn = on_q;
  assign mode = state_q;

endmodule

// File: tb/tb_display_mode_controller.sv
// Scoreboard bench for display_mode_controller (defaults, fast blink)
// plus a six-digit passcode instance.
module tb_display_mode_controller;

  localparam int BHP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        error = 1'b0;
  logic        unlocked = 1'b0;
  logic [2:0]  digit_count = '0;
  logic [15:0] user_entry = '0;
  logic [23:0] hex_out;
  logic [5:0]  display_on;
  logic [1:0]  mode;

  logic [2:0]  d6_cnt = '0;
  logic [23:0] d6_entry = '0;
  logic [23:0] d6_hex;
  logic [5:0]  d6_on;
  logic [1:0]  d6_mode;

  display_mode_controller #(
    .BLINK_HALF_PERIOD(BHP)
  ) dut (
    .clock(clk),
    .reset(rst),
    .error(error),
    .unlocked(unlocked),
    .digitCount(digit_count),
    .userEntry(user_entry),
    .hexOut(hex_out),
    .displayOn(display_on),
    .mode(mode)
  );

  display_mode_controller #(
    .PASSCODE_LENGTH(6),
    .DISPLAYS(6),
    .BLINK_HALF_PERIOD(BHP)
  ) dut6 (
    .clock(clk),
    .reset(rst),
    .error(1'b0),
    .unlocked(1'b0),
    .digitCount(d6_cnt),
    .userEntry(d6_entry),
    .hexOut(d6_hex),
    .displayOn(d6_on),
    .mode(d6_mode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] hex;
    logic [5:0]  on;
    logic [1:0]  mode;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  logic [1:0] m_st = 2'd0;
  int m_age = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 2'd0;
    m_age = 0;
  endtask

  // Drive one cycle of inputs, predict the registered result, compare.
  task automatic step(input logic e, input logic u,
                      input logic [2:0] c, input logic [15:0] ent);
    exp_t x;
    logic [1:0] ns;
    logic ph;
    int n;
    error = e;
    unlocked = u;
    digit_count = c;
    user_entry = ent;
    ns = e ? 2'd1 : (u ? 2'd2 : 2'd0);
    if (ns != m_st) m_age = 0;
    else m_age++;
    m_st = ns;
    ph = ((m_age / BHP) % 2) == 0;
    x.mode = ns;
    x.on = 6'h3F;
    x.hex = '0;
    if (ns == 2'd1) begin
      x.hex = 24'hFCDDED;
      x.on = {6{ph}};
    end else if (ns == 2'd2) begin
      x.hex = 24'hEE0AB1;
    end else begin
      n = (c > 3'd4) ? 4 : int'(c);
      for (int d = 0; d < 6; d++) begin
        x.hex = {x.hex[19:0],
                 (d < n) ? 4'((ent >> (4*(3-d))) & 16'hF) : 4'hE};
      end
      if (n < 4) x.on[n] = ph;
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk("hex", 32'(hex_out), 32'(x.hex));
      chk("on", 32'(display_on), 32'(x.on));
      chk("mode", 32'(mode), 32'(x.mode));
    end
  endtask

  task automatic repeat_step(input int k, input logic e, input logic u,
                             input logic [2:0] c, input logic [15:0] ent);
    for (int i = 0; i < k; i++) step(e, u, c, ent);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hex", 32'(hex_out), 32'hEEEEEE);
    chk("rst_on", 32'(display_on), 32'h3F);
    chk("rst_mode", 32'(mode), 32'd0);
    rst = 1'b0;

    d6_cnt = 3'd6;
    d6_entry = 24'h123456;
    repeat_step(12, 1'b0, 1'b0, 3'd2, 16'h12EE);
    chk("d6_hex_full", 32'(d6_hex), 32'h123456);
    chk("d6_on_full", 32'(d6_on), 32'h3F);
    chk("d6_mode", 32'(d6_mode), 32'd0);
    d6_cnt = 3'd3;

    repeat_step(6, 1'b0, 1'b0, 3'd4, 16'h1234);
    chk("d6_hex_part", 32'(d6_hex), 32'h123EEE);
    repeat_step(3, 1'b0, 1'b0, 3'd7, 16'h1234);
    repeat_step(5, 1'b0, 1'b0, 3'd0, 16'hABCD);

    repeat_step(20, 1'b1, 1'b0, 3'd1, 16'h9000);
    repeat_step(3, 1'b0, 1'b0, 3'd1, 16'h9000);

    repeat_step(3, 1'b1, 1'b1, 3'd0, 16'h0000);
    repeat_step(16, 1'b0, 1'b1, 3'd0, 16'h0000);

    // Abort an error blink while the display is blanked.
    repeat_step(5, 1'b1, 1'b0, 3'd2, 16'h5600);
    chk("blanked", 32'(display_on), 32'h00);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hex", 32'(hex_out), 32'hEEEEEE);
    chk("arst_on", 32'(display_on), 32'h3F);
    chk("arst_mode", 32'(mode), 32'd0);
    model_reset();
    error = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int s = 0; s < 15; s++) begin
      repeat_step(int'($urandom_range(1, 9)),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0,
                  3'($urandom_range(0, 7)),
                  16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/display_mode_controller.md
Name: display_mode_controller

Overview:
Parametrised next-generation display controller for the digital lock. It drives a bank of DISPLAYS hex digits in three modes: passcode entry with an unentered-digit fill and a blinking cursor, a blinking error pattern, and a steady unlocked pattern. Outputs are registered hex nibbles plus a per-digit enable mask. These feed the existing HexTo7SegmentNBit converter, which is gated by the mask at top level.

Parameters:
PASSCODE_LENGTH, 4, digits in unlock code (1..DISPLAYS)
PASSCODE_WIDTH, 4*PASSCODE_LENGTH, bits of userEntry
DISPLAYS, 6, number of seven-segment digits driven
BLINK_HALF_PERIOD, 25000000, clock cycles per blink phase (>=2)
FILL_CODE, 4'hE, nibble shown on unentered or unused digits
ERROR_PATTERN, 24'hFCDDED, DISPLAYS*4-bit error pattern
UNLOCK_PATTERN, 24'hEE0AB1, DISPLAYS*4-bit unlocked pattern

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
error  input  1  level: error condition active
unlocked  input  1  level: lock open
digitCount  input  $clog2(PASSCODE_LENGTH+1)  digits entered so far
userEntry  input  PASSCODE_WIDTH  entered digits, digit 0 in the top nibble
hexOut  output  4*DISPLAYS  registered nibble per display, display 0 in the top nibble
displayOn  output  DISPLAYS  registered per-digit enable, 1 = lit
mode  output  2  registered current state: 0 INPUT, 1 ERROR, 2 UNLOCKED

Behaviour:
- Reset (async, active-high): mode=INPUT, hexOut = all FILL_CODE, displayOn = all 1s, blink counter=0, blinkPhase=1. Reset mid-blink or mid-error aborts immediately.
- All outputs are registered. Next state and next outputs are computed from the current inputs and loaded on the same edge. Latency from any input change to the output is exactly 1 clock.
- State priority each cycle: error=1 -> ERROR; else unlocked=1 -> UNLOCKED; else INPUT. Any state may move to any other in one cycle. Error wins when error and unlocked are both 1.
- Blink timer: counter 0..BLINK_HALF_PERIOD-1.
  - On wrap, the counter returns to 0 and blinkPhase toggles.
  - On any state change, the counter is cleared to 0 and blinkPhase is set to 1. The first visible phase is therefore always "on" for a full BLINK_HALF_PERIOD.
  - The timer free-runs while the state is unchanged, including in UNLOCKED, where it is ignored.
- INPUT:
  - Effective count n = min(digitCount, PASSCODE_LENGTH). Out-of-range counts saturate.
  - Passcode digit k (0..PASSCODE_LENGTH-1) occupies display k.
  - Display k shows the userEntry digit k if k<n, else FILL_CODE.
  - Displays PASSCODE_LENGTH..DISPLAYS-1 show FILL_CODE.
  - Cursor: if n<PASSCODE_LENGTH, displayOn[n]=blinkPhase. All other displays are on. When n=PASSCODE_LENGTH, no cursor and all displays are on.
  - A change in digitCount alone does not reset the blink timer.
- ERROR: hexOut=ERROR_PATTERN; displayOn = all blinkPhase.
- UNLOCKED: hexOut=UNLOCK_PATTERN; displayOn = all 1s.
- Width rules: pattern parameters must be exactly 4*DISPLAYS bits. If DISPLAYS==PASSCODE_LENGTH, there are no fill-padding digits. Elaboration fails if PASSCODE_LENGTH>DISPLAYS or BLINK_HALF_PERIOD<2.
- mode encoding 3 is unreachable. If it is entered, the block recovers to INPUT on the next edge.

Test Plan:
- Defaults, BLINK_HALF_PERIOD=4: pulse reset -> hexOut=24'hEEEEEE, displayOn=6'b111111, mode=0.
- Cursor blink: digitCount=2, userEntry=16'h12EE, error=0, unlocked=0 -> after 1 clock hexOut=24'h12EEEE. displayOn[2] toggles every 4 clocks, starting at 1; other bits stay 1.
- Full entry and saturation: digitCount=4, userEntry=16'h1234 -> hexOut=24'h1234EE, displayOn=6'b111111 steady. digitCount=7 (saturated) -> same outputs.
- Error: error=1 for 20 clocks -> 1 clock later mode=1, hexOut=24'hFCDDED. displayOn is all 1 for 4 clocks, then all 0 for 4 clocks, repeating. When error drops, mode=0 one clock later.
- Priority and unlocked: error=1 and unlocked=1 -> mode=1. Then drop error -> next clock mode=2, hexOut=24'hEE0AB1, displayOn=6'b111111 steady for 16 clocks.
- Reset mid-error and parametrisation: assert reset while mode=1 and the display is blanked -> outputs go to reset values immediately, without waiting for a clock. Rerun with PASSCODE_LENGTH=6, DISPLAYS=6, digitCount=6, userEntry=24'h123456 -> hexOut=24'h123456.
